// File: rtl/alu_pkg.sv
// Shared ALU control constants.
// Holds the 4-bit ALU control codes, the main decoder's ALUOp encodings and the
// R-type funct values. The issue block and the ALU both import this package so
// the two ends of the ctrl interface always agree on the code points.
package alu_pkg;

  // ALU control codes. The ALU returns 0 for CtrlIllegal.
  localparam logic [3:0] CtrlAnd     = 4'd0;
  localparam logic [3:0] CtrlOr      = 4'd1;
  localparam logic [3:0] CtrlAdd     = 4'd2;
  localparam logic [3:0] CtrlSub     = 4'd6;
  localparam logic [3:0] CtrlSlt     = 4'd7;
  localparam logic [3:0] CtrlIllegal = 4'd15;

  // ALUOp encodings from the main decoder.
  localparam logic [2:0] AluOpLwSw  = 3'b000;
  localparam logic [2:0] AluOpBeq   = 3'b001;
  localparam logic [2:0] AluOpRType = 3'b010;
  localparam logic [2:0] AluOpAddi  = 3'b011;
  localparam logic [2:0] AluOpSlti  = 3'b100;
  localparam logic [2:0] AluOpOri   = 3'b101;
  localparam logic [2:0] AluOpAndi  = 3'b110;
  localparam logic [2:0] AluOpRsvd  = 3'b111;

  // R-type funct values.
  localparam logic [5:0] FunctAdd  = 6'h20;
  localparam logic [5:0] FunctAddu = 6'h21;
  localparam logic [5:0] FunctSub  = 6'h22;
  localparam logic [5:0] FunctSubu = 6'h23;
  localparam logic [5:0] FunctAnd  = 6'h24;
  localparam logic [5:0] FunctOr   = 6'h25;
  localparam logic [5:0] FunctSlt  = 6'h2A;

  // Issue buffer depth; pointers are 1 bit wide, so this must stay at 2.
  localparam int unsigned Depth = 2;

  typedef struct packed {
    logic       illegal;
    logic [3:0] ctrl;
  } entry_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control decoder.
// Ports:
//   aluop_i   - ALUOp from the main decoder
//   funct_i   - R-type funct field, only consulted when aluop_i is R-type
//   ctrl_o    - 4-bit ALU control code
//   illegal_o - high when ctrl_o is the ILLEGAL code
module alu_ctrl_decode (
  input  logic [2:0] aluop_i,
  input  logic [5:0] funct_i,
  output logic [3:0] ctrl_o,
  output logic       illegal_o
);
  import alu_pkg::*;

  logic [3:0] funct_ctrl;

  always_comb begin
    funct_ctrl = CtrlIllegal;
    case (funct_i)
      FunctAdd, FunctAddu: funct_ctrl = CtrlAdd;
      FunctSub, FunctSubu: funct_ctrl = CtrlSub;
      FunctAnd:            funct_ctrl = CtrlAnd;
      FunctOr:             funct_ctrl = CtrlOr;
      FunctSlt:            funct_ctrl = CtrlSlt;
      default:             funct_ctrl = CtrlIllegal;
    endcase
  end

  always_comb begin
    ctrl_o = CtrlIllegal;
    unique case (aluop_i)
      AluOpLwSw:  ctrl_o = CtrlAdd;
      AluOpBeq:   ctrl_o = CtrlSub;
      AluOpRType: ctrl_o = funct_ctrl;
      AluOpAddi:  ctrl_o = CtrlAdd;
      AluOpSlti:  ctrl_o = CtrlSlt;
      AluOpOri:   ctrl_o = CtrlOr;
      AluOpAndi:  ctrl_o = CtrlAnd;
      AluOpRsvd:  ctrl_o = CtrlIllegal;
      default:    ctrl_o = CtrlIllegal;
    endcase
  end

  assign illegal_o = (ctrl_o == CtrlIllegal);

endmodule

// File: rtl/alu_ctrl_issue.sv
// ALU control issue stage.
// Decodes ALUOp/funct on the input side and queues {ctrl, illegal} in a
// 2-entry FIFO, issued toward execute with a ready/valid handshake.
// Ports:
//   clk_i, rst_i          - clock, synchronous active-high reset
//   in_valid_i/in_ready_o - decode-side handshake
//   aluop_i, funct_i      - operation to decode (sampled only on accept)
//   out_valid_o/out_ready_i - execute-side handshake
//   ctrl_o, illegal_o     - head entry; forced to 0 when out_valid_o is low
module alu_ctrl_issue (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [2:0] aluop_i,
  input  logic [5:0] funct_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [3:0] ctrl_o,
  output logic       illegal_o
);
  import alu_pkg::*;

  entry_t     mem_q [Depth];
  entry_t     wr_entry;
  entry_t     head;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       push, pop;

  alu_ctrl_decode u_decode (
    .aluop_i   (aluop_i),
    .funct_i   (funct_i),
    .ctrl_o    (wr_entry.ctrl),
    .illegal_o (wr_entry.illegal)
  );

  // Ready depends on registered count only, so out_ready_i never reaches in_ready_o.
  assign in_ready_o  = (count_q != 2'd2);
  assign out_valid_o = (count_q != 2'd0);
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 2'd1;
    else if (pop && !push) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign ctrl_o    = out_valid_o ? head.ctrl : 4'd0;
  assign illegal_o = out_valid_o ? head.illegal : 1'b0;

endmodule

// File: tb/tb_alu_ctrl_issue.sv
module tb_alu_ctrl_issue;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       in_valid_i;
  logic       in_ready_o;
  logic [2:0] aluop_i;
  logic [5:0] funct_i;
  logic       out_valid_o;
  logic       out_ready_i;
  logic [3:0] ctrl_o;
  logic       illegal_o;

  int errors = 0;
  int checks = 0;

  logic [4:0] sb [$];
  logic       stall_prev = 1'b0;
  logic [4:0] head_prev  = 5'd0;

  alu_ctrl_issue dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .aluop_i     (aluop_i),
    .funct_i     (funct_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .ctrl_o      (ctrl_o),
    .illegal_o   (illegal_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode, returns {illegal, ctrl}.
  function automatic logic [4:0] ref_decode(input logic [2:0] op, input logic [5:0] f);
    logic [3:0] c;
    case (op)
      3'd0: c = 4'd2;
      3'd1: c = 4'd6;
      3'd2: begin
        case (f)
          6'h20, 6'h21: c = 4'd2;
          6'h22, 6'h23: c = 4'd6;
          6'h24:        c = 4'd0;
          6'h25:        c = 4'd1;
          6'h2A:        c = 4'd7;
          default:      c = 4'd15;
        endcase
      end
      3'd3: c = 4'd2;
      3'd4: c = 4'd7;
      3'd5: c = 4'd1;
      3'd6: c = 4'd0;
      default: c = 4'd15;
    endcase
    return {(c == 4'd15), c};
  endfunction

  // Inputs change just after posedge, so at negedge they hold the values the
  // next posedge will sample.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Scoreboard monitor.
  always @(negedge clk_i) begin
    if (rst_i) begin
      sb.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check_eq("hold_valid", {31'd0, out_valid_o}, 32'd1);
        check_eq("hold_head", {27'd0, illegal_o, ctrl_o}, {27'd0, head_prev});
      end
      if (!out_valid_o) check_eq("idle_zero", {27'd0, illegal_o, ctrl_o}, 32'd0);
      if (out_valid_o && out_ready_i) begin
        check_eq("sb_avail", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          logic [4:0] exp;
          exp = sb.pop_front();
          check_eq("issue_data", {27'd0, illegal_o, ctrl_o}, {27'd0, exp});
        end
      end
      if (in_valid_i && in_ready_o) sb.push_back(ref_decode(aluop_i, funct_i));
      stall_prev = out_valid_o && !out_ready_i;
      head_prev  = {illegal_o, ctrl_o};
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [2:0] sw_op [16];
  logic [5:0] sw_fn [16];
  logic [5:0] legal_fn [7];
  logic [2:0] sim_op [4];

  initial begin
    sw_op = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd5, 3'd6, 3'd2, 3'd2,
              3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd7, 3'd2};
    sw_fn = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h20, 6'h21,
              6'h22, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h00, 6'h00};
    legal_fn = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A};
    sim_op   = '{3'd1, 3'd4, 3'd5, 3'd6};

    rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0; aluop_i = '0; funct_i = '0;
    repeat (2) step();
    rst_i = 1'b0;
    @(negedge clk_i);
    check_eq("rst_valid", {31'd0, out_valid_o}, 32'd0);
    check_eq("rst_ready", {31'd0, in_ready_o}, 32'd1);
    check_eq("rst_ctrl", {28'd0, ctrl_o}, 32'd0);
    check_eq("rst_illegal", {31'd0, illegal_o}, 32'd0);

    // Single op, one-cycle latency.
    step();
    in_valid_i = 1'b1; aluop_i = 3'd2; funct_i = 6'h22; out_ready_i = 1'b1;
    step();
    in_valid_i = 1'b0;
    @(negedge clk_i);
    check_eq("lat_valid", {31'd0, out_valid_o}, 32'd1);
    check_eq("lat_ctrl", {28'd0, ctrl_o}, 32'd6);
    step();
    @(negedge clk_i);
    check_eq("single_drained", {31'd0, out_valid_o}, 32'd0);

    // Decode sweep at full throughput.
    step();
    for (int i = 0; i < 16; i++) begin
      in_valid_i = 1'b1; aluop_i = sw_op[i]; funct_i = sw_fn[i];
      step();
    end
    in_valid_i = 1'b0;
    repeat (3) step();
    check_eq("sweep_sb_empty", sb.size(), 32'd0);

    // Backpressure.
    out_ready_i = 1'b0; in_valid_i = 1'b1; funct_i = 6'h00;
    aluop_i = 3'd0; step();
    aluop_i = 3'd5; step();
    aluop_i = 3'd4; step();
    @(negedge clk_i);
    check_eq("bp_full", {31'd0, in_ready_o}, 32'd0);
    check_eq("bp_head", {28'd0, ctrl_o}, 32'd2);
    step();
    @(negedge clk_i);
    check_eq("bp_full2", {31'd0, in_ready_o}, 32'd0);
    step();
    out_ready_i = 1'b1;
    step();
    step();
    in_valid_i = 1'b0;
    repeat (3) step();
    check_eq("bp_sb_empty", sb.size(), 32'd0);

    // Simultaneous push/pop at count 1.
    out_ready_i = 1'b0; in_valid_i = 1'b1; aluop_i = 3'd3;
    step();
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      aluop_i = sim_op[i];
      @(negedge clk_i);
      check_eq("sim_ready", {31'd0, in_ready_o}, 32'd1);
      check_eq("sim_valid", {31'd0, out_valid_o}, 32'd1);
      step();
    end
    in_valid_i = 1'b0;
    repeat (3) step();
    check_eq("sim_sb_empty", sb.size(), 32'd0);

    // Reset mid-stream with two entries held.
    out_ready_i = 1'b0; in_valid_i = 1'b1;
    aluop_i = 3'd0; step();
    aluop_i = 3'd1; step();
    aluop_i = 3'd5; rst_i = 1'b1;
    step();
    rst_i = 1'b0; in_valid_i = 1'b0;
    @(negedge clk_i);
    check_eq("mid_rst_valid", {31'd0, out_valid_o}, 32'd0);
    check_eq("mid_rst_ready", {31'd0, in_ready_o}, 32'd1);
    check_eq("mid_rst_ctrl", {28'd0, ctrl_o}, 32'd0);
    step();
    out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check_eq("mid_rst_no_ghost", {31'd0, out_valid_o}, 32'd0);
      step();
    end

    // Random soak.
    for (int i = 0; i < 10000; i++) begin
      in_valid_i  = 1'($urandom_range(0, 1));
      out_ready_i = ($urandom_range(0, 3) != 0);
      aluop_i     = 3'($urandom);
      funct_i     = ($urandom_range(0, 1) != 0) ? legal_fn[$urandom_range(0, 6)] : 6'($urandom);
      step();
    end
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    repeat (4) step();
    @(negedge clk_i);
    check_eq("soak_drained", {31'd0, out_valid_o}, 32'd0);
    check_eq("soak_sb_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_issue.md
# alu_ctrl_issue

Producer side of the ALU control interface: decodes the main decoder's ALUOp plus the R-type funct field into the 4-bit ALU control code and issues it, with a ready/valid handshake, toward the execute stage. A 2-entry buffer decouples decode from execute stalls. It sits between instruction decode and the ALU and registers its outputs, so ctrl codes reach the ALU one stage after decode.

## Interface
- No parameters; entry count fixed at 2.
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- in_valid_i  in  1  decode stage offers an operation
- in_ready_o  out  1  block can accept (buffer not full)
- aluop_i  in  3  ALUOp from main decoder
- funct_i  in  6  instruction funct field (used only when aluop_i = R-type)
- out_valid_o  out  1  head entry valid
- out_ready_i  in  1  execute stage consumes head
- ctrl_o  out  4  ALU control code of head entry
- illegal_o  out  1  head entry decoded from an unsupported ALUOp/funct

## Operation
- ALU ctrl codes: AND=0, OR=1, ADD=2, SUB=6, SLT=7, ILLEGAL=15 (the ALU returns 0 for 15).
- ALUOp decode: 000 ADD (lw/sw); 001 SUB (beq); 010 R-type, use funct; 011 ADD (addi); 100 SLT (slti); 101 OR (ori); 110 AND (andi); 111 ILLEGAL.
- R-type funct decode: 0x20 ADD, 0x21 ADD, 0x22 SUB, 0x23 SUB, 0x24 AND, 0x25 OR, 0x2A SLT; any other funct gives ILLEGAL.
- illegal_o = 1 exactly when the stored code is ILLEGAL. The entry is still issued and must be consumed normally; no entry is ever dropped.
- Buffer: 2-entry FIFO of {ctrl, illegal}, with wr_ptr/rd_ptr (1 bit each, wrap 1→0) and a count of 0..2.
- Push when in_valid_i && in_ready_o. Pop when out_valid_o && out_ready_i.
- in_ready_o = (count != 2), derived from registered count only, with no combinational path from out_ready_i.
- out_valid_o = (count != 0). ctrl_o/illegal_o show the head entry and hold stable while out_valid_o && !out_ready_i.
- Push and pop in the same cycle: count unchanged, both pointers advance. This is legal at count = 1. At count = 2 only pop occurs because ready is low. At count = 0 only push occurs because nothing is valid to pop.
- When out_valid_o = 0, ctrl_o = 0 and illegal_o = 0.

## Timing
- Reset: count = 0, pointers = 0, out_valid_o = 0, in_ready_o = 1, ctrl_o = 0, illegal_o = 0.
- Reset asserted mid-operation flushes all entries at that edge. Handshakes in the reset cycle have no effect.
- Latency: an item accepted at edge N is visible on ctrl_o with out_valid_o = 1 after edge N, when the buffer was empty.
- Throughput: 1 op/cycle sustained when out_ready_i is held high.
- Inputs are sampled only on accepted cycles. aluop_i/funct_i are don't-care otherwise.
- Ordering is strict FIFO.

## Structure
- Package alu_pkg holds:
  - the ctrl code constants (AND, OR, ADD, SUB, SLT, ILLEGAL);
  - the ALUOp encodings;
  - the funct constants.
- The ALU uses the same package constants.
- Sub-module alu_ctrl_decode: purely combinational, {aluop, funct} → {ctrl, illegal}. It is instantiated once on the input side, before the buffer write.
- The top level contains the FIFO storage, pointers, count and handshake logic only.

## Test plan
- Reset then single op: rst_i 1 for 2 cycles, then push aluop=010, funct=0x22 with out_ready_i=1 → out_valid_o=1, ctrl_o=6 one cycle later, then out_valid_o=0.
- Full decode sweep: push all 7 legal ALUOps, and aluop=010 with each listed funct → ctrl_o matches the decode table in order. aluop=111 and funct=0x00 → ctrl_o=15, illegal_o=1.
- Backpressure: out_ready_i=0, push 3 ops (ADD, OR, SLT) → third not accepted (in_ready_o=0 after 2); ctrl_o holds 2. Raise out_ready_i → 2, 1 emitted, then SLT accepted and emitted as 7.
- Simultaneous push/pop at count=1: one entry queued, in_valid_i and out_ready_i both high for 4 cycles → count stays 1 and ctrl_o sequence preserves order.
- Reset mid-stream: buffer holding 2 entries, assert rst_i for one cycle → out_valid_o=0, in_ready_o=1, ctrl_o=0 the next cycle; old entries never appear.
- Random ready/valid soak: 10k cycles against a reference queue model → no loss, duplication or reordering, and ctrl_o stable while stalled.
